// File: rtl/jpeg_dma_pkg.sv
// Shared types and constants for the JPEG block-fetch DMA: FSM states, register map and
// control bit positions.
package jpeg_dma_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StRelease = 3'd2,
    StWaitBuf = 3'd3,
    StWaitSw  = 3'd4,
    StDrain   = 3'd5
  } dma_state_e;

  localparam logic [2:0] RegSrcAddr = 3'd0;
  localparam logic [2:0] RegPitch   = 3'd1;
  localparam logic [2:0] RegEndX    = 3'd2;
  localparam logic [2:0] RegEndY    = 3'd3;
  localparam logic [2:0] RegCtrl    = 3'd4;
  localparam logic [2:0] RegCurAddr = 3'd5;
  localparam logic [2:0] RegBlkCnt  = 3'd6;

  localparam int unsigned CtrlStart = 0;
  localparam int unsigned CtrlNext  = 1;
  localparam int unsigned CtrlAuto  = 2;
  localparam int unsigned CtrlAbort = 3;

  // Counter width that stays legal when the count range collapses to a single value.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jpeg_dma_agen.sv
// Fetch address generator: maps block/row/column position onto the source frame and flags
// line, block and frame boundaries.
module jpeg_dma_agen
  import jpeg_dma_pkg::*;
#(
  parameter int unsigned BLK_W = 8,
  parameter int unsigned BLK_H = 8,
  localparam int unsigned ColW = cnt_width(BLK_W / 4),
  localparam int unsigned RowW = cnt_width(BLK_H)
) (
  input  logic [31:0]     srcaddr,
  input  logic [11:0]     pitch,
  input  logic [7:0]      bx,
  input  logic [7:0]      by,
  input  logic [7:0]      endblock_x,
  input  logic [7:0]      endblock_y,
  input  logic [RowW-1:0] row,
  input  logic [ColW-1:0] col,
  output logic [31:0]     address,
  output logic            endline,
  output logic            endblock,
  output logic            endframe
);

  logic [31:0] line;

  assign line     = 32'(by) * BLK_H + 32'(row);
  assign address  = srcaddr + line * 32'(pitch) + 32'(bx) * BLK_W + (32'(col) << 2);
  assign endline  = (32'(col) == BLK_W / 4 - 1);
  assign endblock = endline && (32'(row) == BLK_H - 1);
  assign endframe = endblock && (bx == endblock_x) && (by == endblock_y);

endmodule

// File: rtl/jpeg_dma_pp.sv
// Block-fetch DMA: reads BLK_W x BLK_H pixel blocks over a Wishbone master into an
// NBUF-deep block BRAM and hands filled buffers to the DCT.
module jpeg_dma_pp
  import jpeg_dma_pkg::*;
#(
  parameter int unsigned BLK_W = 8,
  parameter int unsigned BLK_H = 8,
  parameter int unsigned NBUF  = 2,
  localparam int unsigned BufW  = $clog2(NBUF),
  localparam int unsigned WordW = $clog2(BLK_W * BLK_H / 4)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_we_i,
  input  logic                  dmaen_i,
  output logic [31:0]           wb_dat_o,
  output logic [31:0]           wbm_adr_o,
  output logic [31:0]           wbm_dat_o,
  output logic [3:0]            wbm_sel_o,
  output logic                  wbm_we_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_cyc_o,
  input  logic [31:0]           wbm_dat_i,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  output logic [31:0]           bram_dat_o,
  output logic [BufW+WordW-1:0] bram_adr_o,
  output logic                  bram_we_o,
  output logic                  start_dct_o,
  output logic [BufW-1:0]       dct_buf_o,
  input  logic                  dct_busy_i,
  input  logic                  dct_done_i
);

  localparam int unsigned ColW = cnt_width(BLK_W / 4);
  localparam int unsigned RowW = cnt_width(BLK_H);

  dma_state_e state_q, state_d;
  logic [31:0]     srcaddr_q;
  logic [11:0]     pitch_q;
  logic [7:0]      endx_q, endy_q, bx_q, by_q;
  logic [RowW-1:0] row_q;
  logic [ColW-1:0] col_q;
  logic            auto_q, err_q, started_q;
  logic [NBUF-1:0] full_q, full_d;
  logic [BufW-1:0] wr_q, rd_q;
  logic [15:0]     blkcnt_q;

  logic [2:0]      reg_sel;
  logic            reg_wr, ctrl_wr, do_start, do_next, do_abort, start_go;
  logic            fetching, beat, error_hit, release_buf;
  logic [31:0]     address;
  logic            endline, endblock, endframe;
  logic [WordW-1:0] word;
  logic [NBUF+3:0] status;
  logic            unused_adr;

  assign reg_sel    = wb_adr_i[4:2];
  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};
  assign reg_wr     = dmaen_i && wb_we_i;
  assign ctrl_wr    = reg_wr && (reg_sel == RegCtrl);
  assign do_start   = ctrl_wr && wb_dat_i[CtrlStart];
  assign do_next    = ctrl_wr && wb_dat_i[CtrlNext];
  assign do_abort   = ctrl_wr && wb_dat_i[CtrlAbort];
  assign start_go   = (state_q == StIdle) && do_start && !do_abort;

  // Abort releases the bus in the very cycle it is written, not one cycle later.
  assign fetching  = (state_q == StFetch) && !do_abort;
  assign beat      = fetching && wbm_ack_i && !wbm_err_i;
  assign error_hit = fetching && wbm_err_i;

  assign wbm_adr_o = address;
  assign wbm_dat_o = '0;
  assign wbm_sel_o = 4'b1111;
  assign wbm_we_o  = 1'b0;
  assign wbm_stb_o = fetching;
  assign wbm_cyc_o = fetching;

  assign word       = WordW'(32'(row_q) * (BLK_W / 4) + 32'(col_q));
  assign bram_dat_o = wbm_dat_i;
  assign bram_adr_o = {wr_q, word};
  assign bram_we_o  = beat;

  assign start_dct_o = full_q[rd_q] && !dct_busy_i && !started_q;
  assign dct_buf_o   = rd_q;
  assign release_buf = dct_done_i && full_q[rd_q];

  assign status = {full_q, err_q, auto_q, state_q == StWaitSw, state_q != StIdle};

  jpeg_dma_agen #(
    .BLK_W (BLK_W),
    .BLK_H (BLK_H)
  ) u_agen (
    .srcaddr    (srcaddr_q),
    .pitch      (pitch_q),
    .bx         (bx_q),
    .by         (by_q),
    .endblock_x (endx_q),
    .endblock_y (endy_q),
    .row        (row_q),
    .col        (col_q),
    .address    (address),
    .endline    (endline),
    .endblock   (endblock),
    .endframe   (endframe)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (do_start) state_d = StFetch;
      StFetch: begin
        if (error_hit) begin
          state_d = StIdle;
        end else if (beat) begin
          if (endframe)      state_d = StDrain;
          else if (endblock) state_d = auto_q ? StWaitBuf : StWaitSw;
          else if (endline)  state_d = StRelease;
        end
      end
      StRelease: state_d = StFetch;
      StWaitSw:  if (do_next) state_d = StWaitBuf;
      StWaitBuf: if (!full_q[wr_q]) state_d = StFetch;
      StDrain:   if (full_q == '0) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (do_abort) state_d = StIdle;
  end

  // Set (fetch side) and clear (DCT side) always target different buffers.
  always_comb begin
    full_d = full_q;
    if (beat && endblock) full_d[wr_q] = 1'b1;
    if (release_buf)      full_d[rd_q] = 1'b0;
    if (do_abort || start_go) full_d = '0;
  end

  always_comb begin
    wb_dat_o = '0;
    case (reg_sel)
      RegSrcAddr: wb_dat_o = srcaddr_q;
      RegPitch:   wb_dat_o = 32'(pitch_q);
      RegEndX:    wb_dat_o = 32'(endx_q);
      RegEndY:    wb_dat_o = 32'(endy_q);
      RegCtrl:    wb_dat_o = 32'(status);
      RegCurAddr: wb_dat_o = address;
      RegBlkCnt:  wb_dat_o = 32'(blkcnt_q);
      default:    wb_dat_o = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      srcaddr_q <= '0;
      pitch_q   <= '0;
      endx_q    <= '0;
      endy_q    <= '0;
      auto_q    <= 1'b0;
      err_q     <= 1'b0;
      started_q <= 1'b0;
      full_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      blkcnt_q  <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      if (reg_wr) begin
        case (reg_sel)
          RegSrcAddr: srcaddr_q <= wb_dat_i;
          RegPitch:   pitch_q   <= wb_dat_i[11:0];
          RegEndX:    endx_q    <= wb_dat_i[7:0];
          RegEndY:    endy_q    <= wb_dat_i[7:0];
          RegCtrl:    auto_q    <= wb_dat_i[CtrlAuto];
          default: ;
        endcase
      end
      if (start_go) begin
        bx_q      <= '0;
        by_q      <= '0;
        row_q     <= '0;
        col_q     <= '0;
        wr_q      <= '0;
        rd_q      <= '0;
        err_q     <= 1'b0;
        started_q <= 1'b0;
        blkcnt_q  <= '0;
      end else begin
        if (error_hit) err_q <= 1'b1;
        if (beat) begin
          if (endblock) begin
            col_q    <= '0;
            row_q    <= '0;
            wr_q     <= wr_q + BufW'(1);
            blkcnt_q <= blkcnt_q + 16'd1;
            if (bx_q == endx_q) begin
              bx_q <= '0;
              by_q <= by_q + 8'd1;
            end else begin
              bx_q <= bx_q + 8'd1;
            end
          end else if (endline) begin
            col_q <= '0;
            row_q <= row_q + RowW'(1);
          end else begin
            col_q <= col_q + ColW'(1);
          end
        end
        if (start_dct_o) started_q <= 1'b1;
        if (release_buf) begin
          rd_q      <= rd_q + BufW'(1);
          started_q <= 1'b0;
        end
        if (do_abort) started_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_dma_pp.sv
// Directed bench for jpeg_dma_pp: zero-wait Wishbone slave, simple DCT consumer, and
// hand-computed expectations for addresses, buffer hand-off, status and error/abort/reset.
module tb_jpeg_dma_pp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic        wb_we = 1'b0;
  logic        dmaen = 1'b0;
  logic [31:0] wb_rdat;
  logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel;
  logic        wbm_we, wbm_stb, wbm_cyc, wbm_ack, wbm_err;
  logic [31:0] bram_dat;
  logic [4:0]  bram_adr;
  logic        bram_we;
  logic        start_dct;
  logic [0:0]  dct_buf;
  logic        dct_busy = 1'b0;
  logic        dct_done = 1'b0;

  logic        dct_en = 1'b0;
  logic        err_en = 1'b0;
  int          ack_base = 0;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  int          cyc_cnt = 0;
  int          nack = 0;
  int          n_wr = 0;
  int          n_start = 0;
  logic        pend = 1'b0;
  int          dcnt = 0;
  logic [31:0] wr_adr [0:255];
  logic [31:0] wr_dat [0:255];
  logic [4:0]  wr_bram [0:255];
  int          wr_cyc [0:255];
  logic [0:0]  start_buf [0:15];

  always #5 clk = ~clk;

  jpeg_dma_pp dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wb_adr_i    (wb_adr),
    .wb_dat_i    (wb_dat),
    .wb_we_i     (wb_we),
    .dmaen_i     (dmaen),
    .wb_dat_o    (wb_rdat),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel),
    .wbm_we_o    (wbm_we),
    .wbm_stb_o   (wbm_stb),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack),
    .wbm_err_i   (wbm_err),
    .bram_dat_o  (bram_dat),
    .bram_adr_o  (bram_adr),
    .bram_we_o   (bram_we),
    .start_dct_o (start_dct),
    .dct_buf_o   (dct_buf),
    .dct_busy_i  (dct_busy),
    .dct_done_i  (dct_done)
  );

  // Zero-wait slave; optionally errors the fifth beat after ack_base.
  assign wbm_err   = wbm_stb & err_en & ((nack - ack_base) == 4);
  assign wbm_ack   = wbm_stb & ~wbm_err;
  assign wbm_dat_i = wbm_adr ^ 32'hA5A5_0000;

  // Monitor and DCT consumer; everything sampled on the falling edge.
  always @(negedge clk) begin
    cyc_cnt++;
    if (wbm_ack) nack++;
    if (bram_we && n_wr < 256) begin
      wr_adr[n_wr]  = wbm_adr;
      wr_dat[n_wr]  = bram_dat;
      wr_bram[n_wr] = bram_adr;
      wr_cyc[n_wr]  = cyc_cnt;
      n_wr++;
    end
    dct_done = 1'b0;
    if (pend && dct_en) begin
      if (dcnt == 0) begin
        dct_done = 1'b1;
        pend     = 1'b0;
      end else begin
        dcnt--;
      end
    end
    if (start_dct && n_start < 16) begin
      start_buf[n_start] = dct_buf;
      n_start++;
      pend = 1'b1;
      dcnt = 3;
    end
    dct_busy = pend;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [2:0] r, input logic [31:0] d);
    @(posedge clk);
    #1;
    wb_adr = {27'b0, r, 2'b00};
    wb_dat = d;
    wb_we  = 1'b1;
    dmaen  = 1'b1;
    @(posedge clk);
    #1;
    wb_we = 1'b0;
    dmaen = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] r, output logic [31:0] v);
    wb_adr = {27'b0, r, 2'b00};
    #1;
    v = wb_rdat;
  endtask

  task automatic wait_wr(input string tag, input int target, input int budget);
    int k = 0;
    while (n_wr < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, 32'(n_wr), 32'(target));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic [31:0] v;
    int k = 0;
    reg_rd(3'd4, v);
    while (v[0] && k < budget) begin
      @(posedge clk);
      #1;
      reg_rd(3'd4, v);
      k++;
    end
    check(tag, 32'(v[0]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int w0, s0;

    // Reset state
    cycles(3);
    reg_rd(3'd4, v);  check("rst_status", v, 32'h0);
    reg_rd(3'd0, v);  check("rst_srcaddr", v, 32'h0);
    check("rst_cyc", 32'(wbm_cyc), 32'd0);
    check("rst_bram_we", 32'(bram_we), 32'd0);
    check("rst_start_dct", 32'(start_dct), 32'd0);
    check("sel_const", 32'(wbm_sel), 32'hF);
    rst_n = 1'b1;
    cycles(2);

    // Two blocks, auto mode, DCT consuming
    reg_wr(3'd0, 32'h1000);
    reg_wr(3'd1, 32'd16);
    reg_wr(3'd2, 32'd1);
    reg_wr(3'd3, 32'd0);
    dct_en = 1'b1;
    w0 = n_wr;
    s0 = n_start;
    reg_wr(3'd4, 32'h5);
    wait_wr("t1_writes", w0 + 32, 300);
    wait_idle("t1_idle", 300);
    check("t1_total", 32'(n_wr - w0), 32'd32);
    check("t1_adr0", wr_adr[w0], 32'h1000);
    check("t1_adr1", wr_adr[w0+1], 32'h1004);
    check("t1_adr2", wr_adr[w0+2], 32'h1010);
    check("t1_blk1_adr", wr_adr[w0+16], 32'h1008);
    check("t1_last_adr", wr_adr[w0+31], 32'h107C);
    check("t1_dat2", wr_dat[w0+2], 32'hA5A5_1010);
    check("t1_bram0", 32'(wr_bram[w0]), 32'h00);
    check("t1_bram16", 32'(wr_bram[w0+16]), 32'h10);
    check("t1_bram31", 32'(wr_bram[w0+31]), 32'h1F);
    check("t1_span", 32'(wr_cyc[w0+31] - wr_cyc[w0]), 32'd46);
    check("t1_starts", 32'(n_start - s0), 32'd2);
    check("t1_start_buf0", 32'(start_buf[s0]), 32'd0);
    check("t1_start_buf1", 32'(start_buf[s0+1]), 32'd1);
    reg_rd(3'd4, v);  check("t1_status", v, 32'h4);
    reg_rd(3'd6, v);  check("t1_blkcnt", v, 32'd2);

    // Three blocks, DCT stalled: both buffers fill and fetch waits
    reg_wr(3'd2, 32'd2);
    dct_en = 1'b0;
    w0 = n_wr;
    s0 = n_start;
    reg_wr(3'd4, 32'h5);
    wait_wr("t2_writes", w0 + 32, 300);
    cycles(6);
    check("t2_hold", 32'(n_wr - w0), 32'd32);
    reg_rd(3'd4, v);  check("t2_status", v, 32'h35);
    reg_rd(3'd5, v);  check("t2_curaddr", v, 32'h1010);
    check("t2_starts", 32'(n_start - s0), 32'd1);
    dct_en = 1'b1;
    wait_wr("t2_resume", w0 + 33, 50);
    check("t2_resume_bram", 32'(wr_bram[w0+32]), 32'h00);
    check("t2_resume_adr", wr_adr[w0+32], 32'h1010);
    wait_idle("t2_idle", 400);
    reg_rd(3'd6, v);  check("t2_blkcnt", v, 32'd3);

    // Software-paced mode; a start while busy must be ignored
    reg_wr(3'd2, 32'd1);
    w0 = n_wr;
    reg_wr(3'd4, 32'h1);
    wait_wr("t3_writes", w0 + 16, 100);
    cycles(8);
    reg_rd(3'd4, v);
    check("t3_waitsw", 32'(v[1]), 32'd1);
    check("t3_auto", 32'(v[2]), 32'd0);
    reg_wr(3'd4, 32'h1);
    cycles(2);
    reg_rd(3'd6, v);  check("t3_blkcnt", v, 32'd1);
    reg_rd(3'd4, v);  check("t3_still_waitsw", 32'(v[1]), 32'd1);
    check("t3_no_fetch", 32'(n_wr - w0), 32'd16);
    reg_wr(3'd4, 32'h2);
    wait_wr("t3_next", w0 + 32, 100);
    check("t3_blk1_adr", wr_adr[w0+16], 32'h1008);
    wait_idle("t3_idle", 300);

    // Bus error on the fifth beat
    ack_base = nack;
    err_en = 1'b1;
    w0 = n_wr;
    reg_wr(3'd4, 32'h5);
    cycles(30);
    check("t4_writes", 32'(n_wr - w0), 32'd4);
    reg_rd(3'd4, v);  check("t4_status", v, 32'hC);
    err_en = 1'b0;

    // Asynchronous reset mid-burst
    w0 = n_wr;
    reg_wr(3'd4, 32'h5);
    wait_wr("t5_writes", w0 + 3, 50);
    check("t5_cyc_before", 32'(wbm_cyc), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_cyc_async", 32'(wbm_cyc), 32'd0);
    reg_rd(3'd4, v);  check("t5_status", v, 32'h0);
    reg_rd(3'd0, v);  check("t5_srcaddr", v, 32'h0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);

    // Abort mid-burst
    reg_wr(3'd0, 32'h2000);
    reg_wr(3'd1, 32'd16);
    reg_wr(3'd2, 32'd1);
    w0 = n_wr;
    reg_wr(3'd4, 32'h5);
    wait_wr("t6_writes", w0 + 3, 50);
    check("t6_adr0", wr_adr[w0], 32'h2000);
    wb_adr = 32'h10;
    wb_dat = 32'h8;
    wb_we  = 1'b1;
    dmaen  = 1'b1;
    #1;
    check("t6_cyc_drop", 32'(wbm_cyc), 32'd0);
    check("t6_no_we", 32'(bram_we), 32'd0);
    @(posedge clk);
    #1;
    wb_we = 1'b0;
    dmaen = 1'b0;
    reg_rd(3'd4, v);  check("t6_status", v, 32'h0);
    cycles(5);
    check("t6_writes_after", 32'(n_wr - w0), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jpeg_dma_pp.md
JPEG_DMA_PP -- requirements
Module: jpeg_dma_pp

Interface
REQ-001 SHALL have parameter BLK_W, default 8, block width in pixels (multiple of 4).
REQ-002 SHALL have parameter BLK_H, default 8, block height in lines.
REQ-003 SHALL have parameter NBUF, default 2, number of block buffers in input BRAM (power of 2, >=2).
REQ-004 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have slave ports: wb_adr_i in 32 register address; wb_dat_i in 32 write data; wb_we_i in 1 write strobe; dmaen_i in 1 register select; wb_dat_o out 32 read data (combinational).
REQ-006 SHALL have port wbm  wishbone.master  -  burst-free read master (adr, stb, cyc, sel, we, dat_i, ack, err).
REQ-007 SHALL have BRAM ports: bram_dat_o out 32 = wbm.dat_i; bram_adr_o out log2(NBUF)+log2(BLK_W*BLK_H/4) {buffer, word}; bram_we_o out 1.
REQ-008 SHALL have DCT ports: start_dct_o out 1 one-cycle start; dct_buf_o out log2(NBUF) buffer to process; dct_busy_i in 1; dct_done_i in 1 one-cycle buffer-release pulse.

Function
REQ-009 Registers at wb_adr_i[4:2]: 0 srcaddr[31:0], 1 pitch[11:0], 2 endblock_x[7:0], 3 endblock_y[7:0], 4 control/status, 5 current fetch address (RO), 6 blocks completed (RO, 16 bit).
REQ-010 Control write: bit0 start, bit1 nextblock, bit2 auto mode (stored), bit3 abort; status read: {full[NBUF-1:0], err, auto, waitsw, running}, bits right-aligned.
REQ-011 Fetch address = srcaddr + (by*BLK_H + row)*pitch + bx*BLK_W + 4*col, 32-bit wrap-around arithmetic.
REQ-012 FSM states: IDLE, FETCH, RELEASE, WAITBUF, WAITSW, DRAIN.
REQ-013 IDLE: start -> FETCH, bx=by=row=col=0, wr buffer=0, rd buffer=0, all full flags cleared, err cleared, block counter cleared.
REQ-014 FETCH: stb=cyc=1; each ack writes one word to bram (bram_we_o=1 same cycle) and advances col.
REQ-015 Ack on last word of a line (not last of block) -> RELEASE for exactly one cycle (cyc=0), then FETCH.
REQ-016 Ack on last word of block: set full[wr], wr+=1 mod NBUF, block counter +1; last block (bx=endblock_x, by=endblock_y) -> DRAIN; else auto=1 -> WAITBUF; auto=0 -> WAITSW.
REQ-017 WAITSW: nextblock write -> WAITBUF; WAITBUF: full[wr]=0 -> FETCH, else hold.
REQ-018 DRAIN: all full flags 0 -> IDLE.
REQ-019 Block order: bx increments to endblock_x, then bx=0, by+1.
REQ-020 start_dct_o pulses when full[rd]=1, dct_busy_i=0 and no block of rd already started; dct_buf_o=rd; rd advances on dct_done_i, clearing full[rd].
REQ-021 Simultaneous set of full[wr] and clear via dct_done_i on different buffers SHALL both take effect; same buffer cannot occur (set requires full[wr]=0).
REQ-022 wbm.err during FETCH -> IDLE, err=1 sticky until next start; no bram write that cycle.
REQ-023 Abort in any state -> IDLE next cycle, cyc dropped immediately, full flags cleared.
REQ-024 start while not IDLE SHALL be ignored.
REQ-025 wbm.sel=4'b1111, wbm.we=0, wbm.dat_o=0 always.

Reset
REQ-026 On rst_ni=0 (async): state IDLE, all registers 0, auto=0, full flags 0, start_dct_o=0, bram_we_o=0, wbm.stb=wbm.cyc=0.
REQ-027 Reset mid-burst SHALL drop cyc in the same cycle asynchronously.

Structure
REQ-028 State enum, register offsets and control bit positions SHALL live in package jpeg_dma_pkg.
REQ-029 Address arithmetic SHALL be in sub-module jpeg_dma_agen (parametrised BLK_W, BLK_H), outputs address, endline, endblock, endframe.

Verification
REQ-030 srcaddr=0x1000, pitch=16, endblock_x=1, endblock_y=0, auto=1, ack every cycle -> 32 bram writes, first block addresses 0x1000,0x1004,0x1010..., second starts 0x1008; RELEASE every 2 words; 2 start_dct_o pulses dct_buf_o=0 then 1.
REQ-031 Same, DCT never asserts dct_done_i, 3 blocks -> FSM holds WAITBUF after block 2 with full=2'b11; dct_done_i -> fetch resumes into buffer 0.
REQ-032 auto=0 -> FSM in WAITSW after block 1, status waitsw=1; nextblock write resumes fetch.
REQ-033 wbm.err on 5th word -> IDLE, err=1, exactly 4 bram writes.
REQ-034 rst_ni low during FETCH -> cyc=0 same cycle, all status 0; abort write mid-FETCH -> IDLE next cycle.
